// File: rtl/coeff_write_controller.sv
// Coefficient load sequencer: frames single-band or all-band loads and turns a
// valid/ready coefficient stream into registered RAM write strobes.
module coeff_write_controller #(
    parameter int NUM_BANDS     = 8,
    parameter int TAPS_PER_BAND = 8,
    parameter int ADDR_W        = 6,
    parameter int COEFF_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_enable,
    input  logic                      i_load_start,
    input  logic                      i_all_bands,
    input  logic [2:0]                i_band_sel,
    input  logic                      i_abort,
    input  logic                      i_coeff_valid,
    input  logic signed [COEFF_W-1:0] i_coeff_data,
    output logic                      o_coeff_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic                      o_write_enable,
    output logic                      o_write_done,
    output logic [ADDR_W-1:0]         o_write_address,
    output logic signed [COEFF_W-1:0] o_coeffs_in
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TOTAL = NUM_BANDS * TAPS_PER_BAND;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          idx_q, idx_d, count_q, count_d, idx_inc;
    logic [ADDR_W-1:0]         base_q, base_d, addr_q, addr_d;
    logic signed [COEFF_W-1:0] data_q, data_d;
    logic                      we_q, we_d, wdone_q, wdone_d, done_q, done_d;
    logic                      err_q, err_d, busy_q, busy_d;
    logic                      accept, band_ok;

    assign o_coeff_ready = (state_q == LOAD) & clk_enable & ~i_abort;
    assign accept        = i_coeff_valid & o_coeff_ready;
    assign band_ok       = 32'(i_band_sel) < NUM_BANDS;
    assign idx_inc       = idx_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        wdone_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort wins silently over a coincident start
                if (!i_abort && i_load_start) begin
                    if (i_all_bands) begin
                        base_d  = '0;
                        count_d = CNT_W'(TOTAL);
                        idx_d   = '0;
                        state_d = LOAD;
                    end else if (band_ok) begin
                        base_d  = ADDR_W'(32'(i_band_sel) * TAPS_PER_BAND);
                        count_d = CNT_W'(TAPS_PER_BAND);
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (i_abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    we_d   = 1'b1;
                    addr_d = base_q + idx_q[ADDR_W-1:0];
                    data_d = i_coeff_data;
                    idx_d  = idx_inc;
                    if (idx_inc == count_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (i_abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdone_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            wdone_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            wdone_q <= wdone_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_error         = err_q;
    assign o_write_enable  = we_q;
    assign o_write_done    = wdone_q;
    assign o_write_address = addr_q;
    assign o_coeffs_in     = data_q;
endmodule

// File: doc/coeff_write_controller.md
# coeff_write_controller

Sequences coefficient loads into the equalizer's coefficient write path. Accepts a load command (one band or all bands) from the host or control interface and a valid/ready stream of 16-bit coefficients. Emits the registered write-enable, address, data and write-done strobes that feed the coefficient input register and coefficient RAM. Sits between the control interface and the coefficient write pipeline, and owns address generation and load framing.

## Interface
- NUM_BANDS, 8, number of equalizer bands
- TAPS_PER_BAND, 8, coefficients per band; NUM_BANDS*TAPS_PER_BAND must be ≤ 2^ADDR_W
- ADDR_W, 6, coefficient address width
- COEFF_W, 16, coefficient width (signed)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- clk_enable  in  1  global clock enable; when 0 all state and outputs hold
- i_load_start  in  1  single-cycle load command, sampled only in IDLE
- i_all_bands  in  1  with i_load_start: 1 = load all NUM_BANDS*TAPS_PER_BAND coeffs from address 0
- i_band_sel  in  3  with i_load_start: band to load when i_all_bands=0
- i_abort  in  1  terminate the current load
- i_coeff_valid  in  1  coefficient beat valid
- i_coeff_data  in  COEFF_W  coefficient beat (signed)
- o_coeff_ready  out  1  beat accepted when i_coeff_valid & o_coeff_ready
- o_busy  out  1  load in progress (state ≠ IDLE)
- o_done  out  1  one-cycle pulse: load completed
- o_error  out  1  one-cycle pulse: abort or illegal band
- o_write_enable  out  1  one-cycle write strobe per accepted beat
- o_write_done  out  1  one-cycle pulse after the final write of a load
- o_write_address  out  ADDR_W  write address
- o_coeffs_in  out  COEFF_W  write data (signed)

## Operation
- States: IDLE, LOAD, FLUSH, DONE. State and all registered outputs advance only on clk edges with clk_enable=1.
- IDLE handling:
  - i_abort=1 takes priority: i_load_start is ignored, and no error is raised.
  - i_load_start with i_all_bands=1: base=0, count=NUM_BANDS*TAPS_PER_BAND, go to LOAD.
  - i_load_start with i_all_bands=0 and i_band_sel < NUM_BANDS: base=i_band_sel*TAPS_PER_BAND, count=TAPS_PER_BAND, go to LOAD.
  - i_band_sel ≥ NUM_BANDS: pulse o_error, stay in IDLE.
- o_coeff_ready = (state==LOAD) & clk_enable & ~i_abort. This is the only combinational output.
- LOAD: each accepted beat registers o_write_enable=1, o_write_address=base+idx, o_coeffs_in=i_coeff_data, then idx increments.
  - Idle cycles (no beat) register o_write_enable=0; address and data hold their last values.
  - Acceptance of beat idx=count-1 moves to FLUSH.
- FLUSH: o_write_enable=0 (the last write is on the bus this cycle). Register o_write_done=1 and o_done=1, then go to DONE.
- DONE: o_write_done and o_done are high for this one cycle. Go to IDLE. A load command arriving in DONE is ignored.
- i_abort in LOAD or FLUSH: go to IDLE and pulse o_error.
  - No o_write_done and no o_done.
  - Writes already issued are not retracted.
  - A beat presented in the abort cycle is not accepted.
- i_abort in DONE: ignored; the load completes normally.
- i_load_start outside IDLE is ignored.
- idx counter width is ADDR_W+1. Addresses never wrap: base+idx ≤ NUM_BANDS*TAPS_PER_BAND-1 always.

## Timing
- Reset values: state=IDLE; idx=0; base=0; o_write_enable=0, o_write_done=0, o_write_address=0, o_coeffs_in=0, o_done=0, o_error=0, o_busy=0, o_coeff_ready=0.
- Asserting reset mid-load returns to IDLE immediately, with no done or error pulse.
- With i_load_start at enabled cycle t:
  - o_busy=1 and o_coeff_ready=1 from t+1.
  - A beat accepted at cycle k appears as o_write_enable/address/data at k+1 (latency 1).
- Last beat accepted at k:
  - Write strobe at k+1.
  - o_write_done and o_done at k+2.
  - o_busy=0 and IDLE at k+3.
  - Minimum single-band load with back-to-back beats: 8 accepted beats, then 3 cycles.
- clk_enable=0 cycles are invisible to the sequence: outputs hold, o_coeff_ready=0, and no beat is accepted.

## Test plan
- Reset with rst=0, release, idle 5 cycles -> all outputs 0, o_busy=0, o_coeff_ready=0.
- Start band 3, 8 back-to-back beats 0x0101..0x0108 -> 8 write strobes at addresses 24..31 with matching data, then o_write_done=1 and o_done=1 for one cycle, 2 cycles after the last accepted beat.
- Start all bands, 64 beats with i_coeff_valid toggling every other cycle -> 64 strobes at addresses 0..63 in order, no duplicates, exactly one o_write_done.
- Start band 5, accept 3 beats, i_abort -> writes at 40..42 only, o_error pulses, no o_write_done, o_busy=0 next cycle; a new start on band 0 then loads addresses 0..7 correctly.
- Start band 1, drop clk_enable for 4 cycles mid-load with i_coeff_valid=1 -> no beats accepted and no strobes during the gap; the resumed load produces exactly 8 writes at 8..15.
- i_load_start during LOAD and during DONE, and i_load_start with i_abort in IDLE -> all ignored; address sequence unaffected; no o_error.
